// File: rtl/dsp_fir_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_fir_if
//  Purpose  : Sample-stream bundle of the stereo FIR stage: the incoming
//             sample pair with its tick strobe, and the filtered pair with
//             its valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
interface dsp_fir_if #(
    parameter int DATA_W = 24
);
    logic              tick_in;
    logic [DATA_W-1:0] audio0_in;
    logic [DATA_W-1:0] audio1_in;
    logic [DATA_W-1:0] audio0_out;
    logic [DATA_W-1:0] audio1_out;
    logic              valid_out;

    // Upstream side: drives samples, receives filtered results
    modport master (
        output tick_in, audio0_in, audio1_in,
        input  audio0_out, audio1_out, valid_out
    );

    // Filter side
    modport slave (
        input  tick_in, audio0_in, audio1_in,
        output audio0_out, audio1_out, valid_out
    );
endinterface : dsp_fir_if
`default_nettype wire

// File: rtl/dsp_fir_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_fir_engine
//  Purpose  : Stereo FIR stage. Per accepted tick, one FILTER_TAPS-tap FIR
//             per channel using a single time-shared multiplier; Q1.31
//             coefficients from a 4-filter register file (2 banks x L/R).
//  Options  : DSP_SATURATION_EN - clip results to the DATA_W signed range
//             instead of two's-complement wrap.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_fir_engine #(
    parameter int FILTER_TAPS          = 8,
    parameter int DATA_W               = 24,
    parameter int COEFF_W              = 32,
    parameter int DSP_UNIT_MAX_LATENCY = 64
) (
    input  wire logic                                      clk,
    input  wire logic                                      rst_n,
    dsp_fir_if.slave                                       fir,
    input  wire logic [4*FILTER_TAPS-1:0][COEFF_W-1:0]     dsp_regs_in,
    input  wire logic                                      filter_en_in,
    input  wire logic                                      bank_sel_in,
    input  wire logic                                      clr_in,
    output logic                                           busy_out,
    output logic                                           overrun_out
);

    localparam int c_PTR_W  = $clog2(FILTER_TAPS);
    localparam int c_CIDX_W = $clog2(4*FILTER_TAPS);
    localparam int c_PROD_W = DATA_W + COEFF_W;
    localparam int c_ACC_W  = c_PROD_W + $clog2(FILTER_TAPS);
    localparam int c_FRAC   = COEFF_W - 1;
    localparam logic [c_PTR_W-1:0] c_K_LAST = c_PTR_W'(FILTER_TAPS - 1);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_LOAD    = 3'd1;
    localparam logic [2:0] c_S_MAC_L   = 3'd2;
    localparam logic [2:0] c_S_STORE_L = 3'd3;
    localparam logic [2:0] c_S_MAC_R   = 3'd4;
    localparam logic [2:0] c_S_STORE_R = 3'd5;
    localparam logic [2:0] c_S_BYPASS  = 3'd6;

    // Elaboration-time sanity checks
    if (FILTER_TAPS < 2) begin : g_taps_check
        $error("dsp_fir_engine: FILTER_TAPS must be at least 2");
    end
    if (2*FILTER_TAPS + 3 > DSP_UNIT_MAX_LATENCY) begin : g_latency_check
        $error("dsp_fir_engine: FIR latency exceeds DSP_UNIT_MAX_LATENCY");
    end

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic                      w_accept;
    logic                      w_mac;
    logic                      w_ch;

    logic signed [DATA_W-1:0]  r_samp0;
    logic signed [DATA_W-1:0]  r_samp1;
    logic                      r_bank;
    logic signed [DATA_W-1:0]  r_dl0 [FILTER_TAPS];
    logic signed [DATA_W-1:0]  r_dl1 [FILTER_TAPS];
    logic [c_PTR_W-1:0]        r_wptr;
    logic [c_PTR_W-1:0]        r_base;
    logic [c_PTR_W-1:0]        r_k;

    logic [c_PTR_W-1:0]        w_didx;
    logic [c_CIDX_W-1:0]       w_cidx;
    logic signed [DATA_W-1:0]  w_x;
    logic signed [COEFF_W-1:0] w_coef;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [DATA_W-1:0]         w_result;
    logic [DATA_W-1:0]         r_res0;

    logic [DATA_W-1:0]         r_out0;
    logic [DATA_W-1:0]         r_out1;
    logic                      r_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; a clear always returns the engine to idle
    always_comb begin
        w_next = r_state;
        if (clr_in) begin
            w_next = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE:    if (fir.tick_in) w_next = filter_en_in ? c_S_LOAD : c_S_BYPASS;
                c_S_LOAD:    w_next = c_S_MAC_L;
                c_S_MAC_L:   if (r_k == c_K_LAST) w_next = c_S_STORE_L;
                c_S_STORE_L: w_next = c_S_MAC_R;
                c_S_MAC_R:   if (r_k == c_K_LAST) w_next = c_S_STORE_R;
                c_S_STORE_R: w_next = c_S_IDLE;
                c_S_BYPASS:  w_next = c_S_IDLE;
                default:     w_next = c_S_IDLE;
            endcase
        end
    end

    // State-decoded controls and status outputs
    always_comb begin
        busy_out    = (r_state != c_S_IDLE);
        w_accept    = (r_state == c_S_IDLE) && fir.tick_in && !clr_in;
        overrun_out = (r_state != c_S_IDLE) && fir.tick_in && !clr_in;
        w_mac       = (r_state == c_S_MAC_L) || (r_state == c_S_MAC_R);
        w_ch        = (r_state == c_S_MAC_R);
    end

    // Capture the sample pair and the bank choice on an accepted tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp0 <= '0;
            r_samp1 <= '0;
            r_bank  <= 1'b0;
        end else if (w_accept) begin
            r_samp0 <= fir.audio0_in;
            r_samp1 <= fir.audio1_in;
            r_bank  <= bank_sel_in;
        end
    end

    // Circular delay lines: new sample lands at the write pointer as x[n]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FILTER_TAPS; i++) begin
                r_dl0[i] <= '0;
                r_dl1[i] <= '0;
            end
            r_wptr <= '0;
            r_base <= '0;
        end else if (clr_in) begin
            for (int i = 0; i < FILTER_TAPS; i++) begin
                r_dl0[i] <= '0;
                r_dl1[i] <= '0;
            end
            r_wptr <= '0;
            r_base <= '0;
        end else if (r_state == c_S_LOAD || r_state == c_S_BYPASS) begin
            r_dl0[r_wptr] <= r_samp0;
            r_dl1[r_wptr] <= r_samp1;
            r_base        <= r_wptr;
            r_wptr        <= (r_wptr == c_K_LAST) ? '0 : r_wptr + 1'b1;
        end
    end

    // Tap counter, restarting for each channel pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_k <= '0;
        else if (!clr_in && w_mac && r_k != c_K_LAST) r_k <= r_k + 1'b1;
        else                                       r_k <= '0;
    end

    // Shared multiplier operand selection: x[n-k] and coefficient of filter 2*bank+ch
    always_comb begin
        w_didx = (r_base >= r_k) ? (r_base - r_k)
                                 : (r_base + c_PTR_W'(FILTER_TAPS) - r_k);
        w_cidx = c_CIDX_W'({r_bank, w_ch}) * c_CIDX_W'(FILTER_TAPS) + c_CIDX_W'(r_k);
        w_x    = w_ch ? r_dl1[w_didx] : r_dl0[w_didx];
        w_coef = dsp_regs_in[w_cidx];
        w_prod = c_PROD_W'(w_x) * c_PROD_W'(w_coef);
    end

`ifdef DSP_SATURATION_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;
    logic signed [c_ACC_W-1:0] w_shift;

    // Floor-shift back to sample scale and clip to the signed sample range
    always_comb begin
        w_shift = r_acc >>> c_FRAC;
        if (w_shift > c_SAT_MAX)      w_result = c_SAT_MAX[DATA_W-1:0];
        else if (w_shift < c_SAT_MIN) w_result = c_SAT_MIN[DATA_W-1:0];
        else                          w_result = w_shift[DATA_W-1:0];
    end
`else
    // Floor-shift back to sample scale and keep the low bits (wraps)
    always_comb begin
        w_result = r_acc[c_FRAC +: DATA_W];
    end
`endif

    // Accumulator: cleared before each channel pass, one product per MAC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_res0 <= '0;
        end else if (r_state == c_S_LOAD) begin
            r_acc  <= '0;
        end else if (r_state == c_S_STORE_L) begin
            r_res0 <= w_result;
            r_acc  <= '0;
        end else if (w_mac) begin
            r_acc  <= r_acc + c_ACC_W'(w_prod);
        end
    end

    // Output registers: updated only on completion, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out0  <= '0;
            r_out1  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!clr_in && r_state == c_S_STORE_R) begin
                r_out0  <= r_res0;
                r_out1  <= w_result;
                r_valid <= 1'b1;
            end else if (!clr_in && r_state == c_S_BYPASS) begin
                r_out0  <= r_samp0;
                r_out1  <= r_samp1;
                r_valid <= 1'b1;
            end
        end
    end

    assign fir.audio0_out = r_out0;
    assign fir.audio1_out = r_out1;
    assign fir.valid_out  = r_valid;

endmodule : dsp_fir_engine
`default_nettype wire

// File: tb/tb_dsp_fir_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_fir_engine
//  Purpose  : Directed self-checking bench for dsp_fir_engine (4 taps).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_fir_engine;

    localparam int N   = 4;
    localparam int DW  = 24;
    localparam int CW  = 32;
    localparam int LAT = 2*N + 3;

    logic                     clk;
    logic                     rst_n;
    logic [4*N-1:0][CW-1:0]   regs;
    logic                     filter_en;
    logic                     bank_sel;
    logic                     clr;
    logic                     busy;
    logic                     overrun;

    int n_vec = 0;
    int n_err = 0;

    dsp_fir_if #(.DATA_W(DW)) fir_if ();

    dsp_fir_engine #(
        .FILTER_TAPS          (N),
        .DATA_W               (DW),
        .COEFF_W              (CW),
        .DSP_UNIT_MAX_LATENCY (32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fir          (fir_if),
        .dsp_regs_in  (regs),
        .filter_en_in (filter_en),
        .bank_sel_in  (bank_sel),
        .clr_in       (clr),
        .busy_out     (busy),
        .overrun_out  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input logic en, input logic bank);
        fir_if.audio0_in = a0;
        fir_if.audio1_in = a1;
        filter_en        = en;
        bank_sel         = bank;
        fir_if.tick_in   = 1'b1;
        step(1);
        fir_if.tick_in   = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!fir_if.valid_out && cyc < 200) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic run_fir(input string tag, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                           input logic bank, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int cyc;
        send(a0, a1, 1'b1, bank);
        wait_valid(cyc);
        check_val({tag, "_lat"}, cyc, LAT);
        check_val({tag, "_l"}, fir_if.audio0_out, e0);
        check_val({tag, "_r"}, fir_if.audio1_out, e1);
    endtask

    task automatic run_quiet(input logic [DW-1:0] a0, input logic [DW-1:0] a1);
        int cyc;
        send(a0, a1, 1'b1, 1'b0);
        wait_valid(cyc);
        check_val("quiet_lat", cyc, LAT);
    endtask

    initial begin
        int cyc;
        int nval;
        logic [DW-1:0] last0;

        rst_n            = 1'b0;
        regs             = '0;
        filter_en        = 1'b0;
        bank_sel         = 1'b0;
        clr              = 1'b0;
        fir_if.tick_in   = 1'b0;
        fir_if.audio0_in = '0;
        fir_if.audio1_in = '0;
        step(2);

        // Reset state
        check_val("rst_out0",  fir_if.audio0_out, 24'h0);
        check_val("rst_out1",  fir_if.audio1_out, 24'h0);
        check_val("rst_valid", fir_if.valid_out, 1'b0);
        check_val("rst_busy",  busy, 1'b0);
        check_val("rst_ovr",   overrun, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Single-tap gain of 0.5 on every filter
        for (int f = 0; f < 4; f++) regs[f*N] = 32'h4000_0000;
        run_fir("gain", 24'h100000, 24'h100000, 1'b0, 24'h080000, 24'h080000);
        step(1);
        check_val("valid_pulse", fir_if.valid_out, 1'b0);
        step(3);
        check_val("hold_l", fir_if.audio0_out, 24'h080000);

        // Impulse response: left taps 0.5, 0.25; right all zero
        regs    = '0;
        regs[0] = 32'h4000_0000;
        regs[1] = 32'h2000_0000;
        pulse_clr();
        run_fir("imp0", 24'h7FFFFF, 24'h7FFFFF, 1'b0, 24'h3FFFFF, 24'h000000);
        run_fir("imp1", 24'h000000, 24'h000000, 1'b0, 24'h1FFFFF, 24'h000000);
        run_fir("imp2", 24'h000000, 24'h000000, 1'b0, 24'h000000, 24'h000000);

        // Bank 1: near-unity tap0 on both channels
        regs[2*N] = 32'h7FFF_FFFF;
        regs[3*N] = 32'h7FFF_FFFF;
        run_fir("bank1", 24'h000010, 24'h000010, 1'b1, 24'h00000F, 24'h00000F);
        send(24'h000010, 24'hFFFFF0, 1'b1, 1'b1);
        step(3);
        bank_sel = 1'b0;
        wait_valid(cyc);
        check_val("bank_hold_lat", cyc + 3, LAT);
        check_val("bank_hold_l", fir_if.audio0_out, 24'h00000F);
        check_val("bank_hold_r", fir_if.audio1_out, 24'hFFFFF0);

        // Full-scale accumulation: positive then negative overflow
        for (int i = 0; i < 4*N; i++) regs[i] = 32'h7FFF_FFFF;
        pulse_clr();
        run_fir("sat_t1", 24'h7FFFFF, 24'h7FFFFF, 1'b0, 24'h7FFFFE, 24'h7FFFFE);
        run_quiet(24'h7FFFFF, 24'h7FFFFF);
        run_quiet(24'h7FFFFF, 24'h7FFFFF);
`ifdef DSP_SATURATION_EN
        run_fir("sat_pos", 24'h7FFFFF, 24'h7FFFFF, 1'b0, 24'h7FFFFF, 24'h7FFFFF);
`else
        run_fir("wrap_pos", 24'h7FFFFF, 24'h7FFFFF, 1'b0, 24'hFFFFFB, 24'hFFFFFB);
`endif
        run_quiet(24'h800000, 24'h800000);
        run_quiet(24'h800000, 24'h800000);
        run_quiet(24'h800000, 24'h800000);
`ifdef DSP_SATURATION_EN
        run_fir("sat_neg", 24'h800000, 24'h800000, 1'b0, 24'h800000, 24'h800000);
`else
        run_fir("wrap_neg", 24'h800000, 24'h800000, 1'b0, 24'h000000, 24'h000000);
`endif

        // Overrun: second tick five cycles into a computation
        regs    = '0;
        regs[0] = 32'h4000_0000;
        regs[1] = 32'h2000_0000;
        pulse_clr();
        send(24'h7FFFFF, 24'h000000, 1'b1, 1'b0);
        step(4);
        fir_if.audio0_in = 24'h123456;
        fir_if.tick_in   = 1'b1;
        #1;
        check_val("ovr_pulse", overrun, 1'b1);
        step(1);
        fir_if.tick_in = 1'b0;
        #1;
        check_val("ovr_low", overrun, 1'b0);
        nval  = 0;
        last0 = '0;
        for (int i = 0; i < 2*LAT; i++) begin
            if (fir_if.valid_out) begin
                nval++;
                last0 = fir_if.audio0_out;
            end
            step(1);
        end
        check_val("ovr_nvalid", nval, 1);
        check_val("ovr_out", last0, 24'h3FFFFF);

        // Clear while busy aborts and wipes history
        send(24'h7FFFFF, 24'h000000, 1'b1, 1'b0);
        step(5);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_val("clr_busy", busy, 1'b0);
        nval = 0;
        for (int i = 0; i < 2*LAT; i++) begin
            if (fir_if.valid_out) nval++;
            step(1);
        end
        check_val("clr_nvalid", nval, 0);
        check_val("clr_hold", fir_if.audio0_out, 24'h3FFFFF);
        run_fir("post_clr", 24'h000000, 24'h000000, 1'b0, 24'h000000, 24'h000000);

        // Clear and tick together: tick dropped silently
        clr            = 1'b1;
        fir_if.tick_in = 1'b1;
        #1;
        check_val("clrtick_ovr", overrun, 1'b0);
        step(1);
        clr            = 1'b0;
        fir_if.tick_in = 1'b0;
        check_val("clrtick_busy", busy, 1'b0);

        // Bypass, and bypass samples still enter the delay line
        send(24'hABCDEF, 24'h123456, 1'b0, 1'b0);
        wait_valid(cyc);
        check_val("byp_lat", cyc, 1);
        check_val("byp_l", fir_if.audio0_out, 24'hABCDEF);
        check_val("byp_r", fir_if.audio1_out, 24'h123456);
        step(1);
        run_fir("byp_hist", 24'h000000, 24'h000000, 1'b0, 24'hEAF37B, 24'h000000);

        // Asynchronous reset in the middle of the MAC phase
        send(24'h100000, 24'h100000, 1'b1, 1'b0);
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out0",  fir_if.audio0_out, 24'h0);
        check_val("arst_out1",  fir_if.audio1_out, 24'h0);
        check_val("arst_busy",  busy, 1'b0);
        check_val("arst_valid", fir_if.valid_out, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dsp_fir_engine
`default_nettype wire

// File: doc/dsp_fir_engine.md
Name: dsp_fir_engine

Overview:
Stereo FIR filter stage of audioport, between the audio buffer/CDC front end and the serial output stage. On each sample tick it takes one 24-bit left/right sample pair and computes a FILTER_TAPS-tap FIR per channel from Q1.31 coefficients held in the dsp register file, loaded through APB from the filter-tap set. It uses one time-shared multiplier and emits a filtered sample pair with a valid pulse.

Parameters:
FILTER_TAPS, audioport_pkg FILTER_TAPS, taps per channel filter
DATA_W, 24, audio sample width (signed)
COEFF_W, 32, coefficient width (signed Q1.31)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_in  in  1  one-cycle sample strobe
audio0_in  in  DATA_W  left sample, signed
audio1_in  in  DATA_W  right sample, signed
dsp_regs_in  in  4*FILTER_TAPS x COEFF_W  coefficient file, 4 filters
filter_en_in  in  1  1 = FIR, 0 = bypass
bank_sel_in  in  1  coefficient bank select
clr_in  in  1  synchronous clear of delay lines
audio0_out  out  DATA_W  filtered left sample
audio1_out  out  DATA_W  filtered right sample
valid_out  out  1  one-cycle pulse, outputs updated
busy_out  out  1  high while computing
overrun_out  out  1  one-cycle pulse, tick_in dropped while busy

Behaviour:
- Reset (async, rst_n=0): all outputs 0, delay lines 0, state IDLE, accumulator 0.
- Coefficient index: filter f = 2*bank_sel + ch (ch 0 = left, 1 = right). Tap k uses dsp_regs_in[f*FILTER_TAPS+k] and multiplies x[n-k].
- bank_sel_in and filter_en_in are sampled on the accepted tick and held for that computation.
- Delay line: per-channel circular buffer of FILTER_TAPS samples with write pointer. On an accepted tick the new sample is written at the pointer and becomes x[n]. The pointer wraps from FILTER_TAPS-1 to 0.
- FSM states:
  - IDLE: tick_in && filter_en -> LOAD. tick_in && !filter_en -> BYPASS.
  - LOAD: write samples, clear accumulator -> MAC_L.
  - MAC_L: one product per cycle for k=0..FILTER_TAPS-1 -> STORE_L.
  - STORE_L -> MAC_R.
  - MAC_R -> STORE_R.
  - STORE_R: update outputs, valid_out=1 -> IDLE.
  - BYPASS: outputs = inputs, samples still written to delay lines, valid_out=1 -> IDLE.
- Latency, tick to valid_out: 2*FILTER_TAPS+3 cycles in FIR mode, 1 cycle in bypass. FIR latency must be <= DSP_UNIT_MAX_LATENCY; a static assertion checks this.
- Arithmetic:
  - Product is DATA_W+COEFF_W bits signed.
  - Accumulator is DATA_W+COEFF_W+$clog2(FILTER_TAPS) bits, with no internal overflow.
  - Result = accumulator arithmetic-shifted right by 31 (floor), then reduced to DATA_W per the Optional Feature.
- busy_out is high in every state except IDLE.
- tick_in while busy: sample discarded, overrun_out pulses that cycle, running computation unaffected.
- clr_in:
  - In IDLE: zeroes both delay lines and the pointer next cycle; outputs hold.
  - While busy: aborts the computation, returns to IDLE, no valid_out.
  - clr_in and tick_in in the same cycle: clear wins, tick dropped, no overrun pulse.
- Async reset mid-computation: immediate return to reset state, no valid_out.
- audio*_out hold their value between valid_out pulses.

Optional Feature:
Macro DSP_SATURATION_EN.
- Defined: shifted result outside [-2^23, 2^23-1] clips to 0x800000 / 0x7FFFFF.
- Undefined: result truncated to low DATA_W bits (two's-complement wrap).

Test Plan:
1. Single-tap gain: tap0 = 0x40000000, others 0, filter_en=1; audio0_in = audio1_in = 0x100000 -> both outputs 0x080000, valid_out exactly 2*FILTER_TAPS+3 cycles after the tick.
2. Impulse response: bank0 left tap0 = 0x40000000, tap1 = 0x20000000; input 0x7FFFFF then zeros over 3 ticks -> left out 0x3FFFFF, 0x1FFFFF, 0x000000. Right uses bank0 right coefficients, all 0 -> right out 0.
3. Bank switch: bank1 tap0 = 0x7FFFFFFF, bank_sel_in=1, input 0x000010 -> output 0x00000F. bank_sel changed mid-computation -> no effect until the next tick.
4. Saturation: all taps 0x7FFFFFFF, steady input 0x7FFFFF for FILTER_TAPS ticks -> with DSP_SATURATION_EN output 0x7FFFFF. Without it, output equals the low 24 bits of the floor result.
5. Overrun/clear: second tick 5 cycles after the first -> overrun_out pulse, one valid_out only. clr_in while busy -> no valid_out. The next impulse test then shows zero history.
6. Bypass and reset: filter_en=0, input 0xABCDEF -> output 0xABCDEF one cycle later. rst_n low mid-MAC -> all outputs 0, busy_out 0 immediately.
